serial_alu_seq: RTL
===================

# serial_alu_seq

Bit-serial multi-bit ALU sequencer built around the team's 1-bit ALU slice. It accepts two WIDTH-bit operands plus the same opsel/mode encoding the 1-bit slice uses. It then processes one bit per clock, LSB first, chaining the carry through an internal flop. It returns a registered WIDTH-bit result and a carry-out with a done pulse, and sits directly upstream of any consumer that previously used a single 1-bit result.

## Interface
- WIDTH, default 8: operand/result width in bits, ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: one clock, synchronous, active-high.
- start  input  1  request; accepted only when busy = 0.
- a  input  WIDTH  operand 1, sampled on accepted start.
- b  input  WIDTH  operand 2, sampled on accepted start.
- opsel  input  3  operation select, sampled on accepted start.
- mode  input  1  0 = arithmetic, 1 = logic; sampled on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result/cout update.
- result  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out; holds until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE to RUN on start.
  - RUN to DONE when the bit counter reaches WIDTH-1.
  - DONE to IDLE when start = 0.
- On accept, latch a, b, opsel and mode into shift registers, clear the bit counter, and load the carry flop with the op's initial carry.
- Each RUN cycle:
  - Compute one bit from the operand LSBs and the carry flop.
  - Shift the result bit into the result shift register from the MSB side.
  - Shift both operands right and update the carry.
- Arithmetic (mode=0); effective operands x, y and initial carry c0:
  - 000 add: x=a, y=b, c0=0.
  - 001 sub a-b: x=a, y=~b, c0=1.
  - 010 inc a: x=a, y=0, c0=1.
  - 011 dec a: x=a, y=all-ones, c0=0.
  - 100 pass a: x=a, y=0, c0=0.
  - 101 pass b: x=0, y=b, c0=0.
  - 110 sub b-a: x=~a, y=b, c0=1.
  - 111 reserved.
  - Bit rule: sum = x^y^c; carry = majority(x,y,c).
  - cout = final carry. For sub this means 1 = no borrow.
  - For pass ops cout is forced 0.
- Logic (mode=1), bitwise, cout = 0:
  - 000 AND.
  - 001 OR.
  - 010 XOR.
  - 011 NOT a.
  - 100 NOR.
  - 101–111 reserved.
- Reserved codes: still run the full WIDTH cycles, then produce result = 0 and cout = 0.
- All arithmetic is modulo 2^WIDTH; no overflow flag.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0; FSM in IDLE; internal registers cleared.
- Accept edge = edge k, where start=1 and busy=0 are sampled.
- busy is high for exactly WIDTH cycles, after edges k .. k+WIDTH-1.
- Bit i is computed in the cycle after edge k+i.
- At edge k+WIDTH, result and cout update, done goes high for one cycle, and busy drops.
- Latency: start sampled to done high = WIDTH+1 edges.
- Back-to-back: start held high in the DONE cycle is accepted. That gives one operation per WIDTH+1 cycles; done pulses separately per operation.
- start while busy=1 is ignored. Operands may change freely during RUN without effect.
- rst during RUN aborts:
  - Next cycle: busy=0, done=0, result=0, cout=0; no done pulse for the aborted op.
- rst and start both high: rst wins; start is not accepted.
- result/cout never show partial values; they change only on the completion edge.

## Test plan
- WIDTH=8, add, a=0xFF, b=0x01:
  - busy high for 8 cycles.
  - done on the 9th edge after accept.
  - result=0x00, cout=1.
- Sub a=0x05, b=0x07 -> result=0xFE, cout=0.
- Sub a=0x07, b=0x05 -> result=0x02, cout=1.
- Dec a=0x00 -> result=0xFF, cout=0.
- Inc a=0x7F -> result=0x80, cout=0.
- Logic sweep with a=0xA5, b=0x0F (cout=0 for all):
  - AND = 0x05.
  - OR = 0xAF.
  - XOR = 0xAA.
  - NOT a = 0x5A.
  - NOR = 0x50.
  - Reserved logic code 101 -> 0x00.
- Start add 0x10+0x20, pulse start again with new operands on cycle 3, then assert rst on cycle 5:
  - Second start is ignored.
  - After rst: busy=0, result=0, no done pulse.
  - A fresh add 0x10+0x20 then yields 0x30, cout=0.
- Back-to-back, start held high for 2 ops (add 0x01+0x01, then XOR 0xFF^0x0F):
  - Two done pulses, 9 cycles apart.
  - Results 0x02, then 0xF0.
  - result holds 0x02 between the two completions.

Source files
------------

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial WIDTH-bit ALU. Processes one bit per clock, LSB first,
// with the carry chained through a flop. Registered result/cout with a done pulse.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opsel,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Arithmetic opsel codes (mode = 0)
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_DEC   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SUBBA = 3'd6;

  // Logic opsel codes (mode = 1)
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOTA = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] result_reg;
  logic [2:0]       opsel_reg;
  logic             mode_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             cout_reg;

  logic             x_bit;
  logic             y_bit;
  logic             logic_bit;
  logic             sum_bit;
  logic             carry_next;
  logic             bit_out;
  logic             op_valid;
  logic             cout_en;
  logic [WIDTH-1:0] res_next;

  function automatic logic initial_carry(input logic m, input logic [2:0] op);
    return !m && (op == OP_SUB || op == OP_INC || op == OP_SUBBA);
  endfunction

  // One bit slice: effective operands, then full-adder or bitwise logic.
  always_comb begin
    x_bit     = 1'b0;
    y_bit     = 1'b0;
    logic_bit = 1'b0;
    case (opsel_reg)
      OP_ADD:   begin x_bit = a_reg[0];  y_bit = b_reg[0];  end
      OP_SUB:   begin x_bit = a_reg[0];  y_bit = ~b_reg[0]; end
      OP_INC:   begin x_bit = a_reg[0];  y_bit = 1'b0;      end
      OP_DEC:   begin x_bit = a_reg[0];  y_bit = 1'b1;      end
      OP_PASSA: begin x_bit = a_reg[0];  y_bit = 1'b0;      end
      OP_PASSB: begin x_bit = 1'b0;      y_bit = b_reg[0];  end
      OP_SUBBA: begin x_bit = ~a_reg[0]; y_bit = b_reg[0];  end
      default:  begin x_bit = 1'b0;      y_bit = 1'b0;      end
    endcase
    case (opsel_reg)
      OP_AND:  logic_bit = a_reg[0] & b_reg[0];
      OP_OR:   logic_bit = a_reg[0] | b_reg[0];
      OP_XOR:  logic_bit = a_reg[0] ^ b_reg[0];
      OP_NOTA: logic_bit = ~a_reg[0];
      OP_NOR:  logic_bit = ~(a_reg[0] | b_reg[0]);
      default: logic_bit = 1'b0;
    endcase
    sum_bit    = x_bit ^ y_bit ^ carry_reg;
    carry_next = (x_bit & y_bit) | (x_bit & carry_reg) | (y_bit & carry_reg);
    bit_out    = mode_reg ? logic_bit : sum_bit;
  end

  assign op_valid = mode_reg ? (opsel_reg <= OP_NOR) : (opsel_reg != 3'd7);
  assign cout_en  = !mode_reg && (opsel_reg == OP_ADD || opsel_reg == OP_SUB ||
                                  opsel_reg == OP_INC || opsel_reg == OP_DEC ||
                                  opsel_reg == OP_SUBBA);

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
    assign res_next[gi] = res_reg[gi+1];
  end
  assign res_next[WIDTH-1] = bit_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      result_reg <= '0;
      opsel_reg  <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cout_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            opsel_reg <= opsel;
            mode_reg  <= mode;
            carry_reg <= initial_carry(mode, opsel);
            cnt_reg   <= '0;
            res_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= carry_next;
          res_reg   <= res_next;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            result_reg <= op_valid ? res_next : '0;
            cout_reg   <= cout_en & carry_next;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= S_DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign cout   = cout_reg;

endmodule
